// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: acquisition and lock supervisor for the PLL loop
// (PFD -> LoopFilter -> DCO -> Frequency_Divider).
// Measures PFD phase-error activity per fixed window of WIN_LEN clk cycles. Holds the loop
// in reset at start-up, selects coarse or fine loop-filter gain, declares lock, detects
// loss of lock and retries acquisition on timeout.
//
// Ports
//   clk_i       system clock (same clock as LoopFilter/DCO)
//   rst_ni      asynchronous active-low reset
//   en_i        enable acquisition; 0 forces IDLE
//   up_i, dn_i  PFD up/dn, asynchronous to clk_i
//   clr_lost_i  single-cycle pulse, clears lock_lost_o and acq_fail_o
//   loop_rst_o  1 = hold PFD/LoopFilter/DCO/divider in reset
//   gain_sel_o  1 = coarse gain, 0 = fine gain
//   locked_o    1 while in LOCKED
//   lock_lost_o sticky, set on LOCKED -> FINE
//   acq_fail_o  sticky, set on acquisition timeout
//   state_o     IDLE=0 LOOP_RST=1 COARSE=2 FINE=3 LOCKED=4
//   err_last_o  error count of the last completed window
module pll_lock_ctrl #(
  parameter int unsigned WIN_LEN      = 256,
  parameter int unsigned COARSE_THR   = 64,
  parameter int unsigned FINE_THR     = 8,
  parameter int unsigned LOCK_WINS    = 8,
  parameter int unsigned UNLOCK_WINS  = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned TIMEOUT_WINS = 1024,
  localparam int unsigned ErrW        = $clog2(WIN_LEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            up_i,
  input  logic            dn_i,
  input  logic            clr_lost_i,
  output logic            loop_rst_o,
  output logic            gain_sel_o,
  output logic            locked_o,
  output logic            lock_lost_o,
  output logic            acq_fail_o,
  output logic [2:0]      state_o,
  output logic [ErrW-1:0] err_last_o
);

  // One counter serves both the LOOP_RST hold time and the measurement window.
  localparam int unsigned CntMax = (WIN_LEN > RST_CYCLES) ? WIN_LEN : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned GoodW  = $clog2(LOCK_WINS + 1);
  localparam int unsigned BadW   = $clog2(UNLOCK_WINS + 1);
  localparam int unsigned AcqW   = $clog2(TIMEOUT_WINS + 1);

  localparam logic [CntW-1:0]  WinLast   = CntW'(WIN_LEN - 1);
  localparam logic [CntW-1:0]  RstLast   = CntW'(RST_CYCLES - 1);
  localparam logic [ErrW-1:0]  ErrSat    = ErrW'(WIN_LEN);
  localparam logic [ErrW-1:0]  CoarseThr = ErrW'(COARSE_THR);
  localparam logic [ErrW-1:0]  FineThr   = ErrW'(FINE_THR);
  localparam logic [GoodW-1:0] GoodLast  = GoodW'(LOCK_WINS - 1);
  localparam logic [BadW-1:0]  BadLast   = BadW'(UNLOCK_WINS - 1);
  localparam logic [AcqW-1:0]  AcqLast   = AcqW'(TIMEOUT_WINS - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoopRst = 3'd1,
    StCoarse  = 3'd2,
    StFine    = 3'd3,
    StLocked  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      up_sync_q, dn_sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ErrW-1:0] err_cnt_q, err_cnt_d;
  logic [ErrW-1:0] err_last_q, err_last_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [BadW-1:0] bad_q, bad_d;
  logic [AcqW-1:0] acq_q, acq_d;
  logic            lost_q, lost_d;
  logic            fail_q, fail_d;
  logic            loop_rst_q, loop_rst_d;
  logic            gain_sel_q, gain_sel_d;
  logic            locked_q, locked_d;

  logic            err_now;
  logic            in_win;
  logic            win_end;
  logic            entry;
  logic [ErrW-1:0] err_total;
  logic            set_lost, set_fail;

  // Both PFD outputs high is the PFD's own reset pulse, not phase error.
  assign err_now   = up_sync_q[1] ^ dn_sync_q[1];
  assign in_win    = (state_q == StCoarse) || (state_q == StFine) || (state_q == StLocked);
  assign win_end   = in_win && (cnt_q == WinLast);
  // Window total includes the current cycle's sample.
  assign err_total = (err_cnt_q == ErrSat) ? ErrSat : err_cnt_q + ErrW'(err_now);
  assign entry     = (state_d != state_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d  = state_q;
    set_lost = 1'b0;
    set_fail = 1'b0;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoopRst;
        StLoopRst: begin
          if (cnt_q == RstLast) state_d = StCoarse;
        end
        StCoarse, StFine: begin
          if (win_end) begin
            // Timeout takes precedence over any gain/lock decision in the same window.
            if (acq_q == AcqLast) begin
              state_d  = StLoopRst;
              set_fail = 1'b1;
            end else if (state_q == StCoarse) begin
              if (err_total <= CoarseThr) state_d = StFine;
            end else if (err_total <= FineThr) begin
              if (good_q == GoodLast) state_d = StLocked;
            end else if (err_total > CoarseThr) begin
              state_d = StCoarse;
            end
          end
        end
        StLocked: begin
          if (win_end && (err_total > FineThr) && (bad_q == BadLast)) begin
            state_d  = StFine;
            set_lost = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Counters and window accounting
  always_comb begin
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    err_last_d = err_last_q;
    good_d     = good_q;
    bad_d      = bad_q;
    acq_d      = acq_q;

    if (win_end) err_last_d = err_total;

    if (entry || !(in_win || (state_q == StLoopRst)) || win_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (entry || !in_win || win_end) begin
      err_cnt_d = '0;
    end else begin
      err_cnt_d = err_total;
    end

    if (entry) begin
      good_d = '0;
    end else if ((state_q == StFine) && win_end) begin
      good_d = (err_total <= FineThr) ? good_q + GoodW'(1) : '0;
    end

    if (entry) begin
      bad_d = '0;
    end else if ((state_q == StLocked) && win_end) begin
      bad_d = (err_total > FineThr) ? bad_q + BadW'(1) : '0;
    end

    // Acquisition timer spans COARSE and FINE together; cleared everywhere else.
    if ((state_d != StCoarse) && (state_d != StFine)) begin
      acq_d = '0;
    end else if (((state_q == StCoarse) || (state_q == StFine)) && win_end) begin
      acq_d = acq_q + AcqW'(1);
    end

    // Set wins over a coincident clear.
    lost_d = set_lost | (lost_q & ~clr_lost_i);
    fail_d = set_fail | (fail_q & ~clr_lost_i);
  end

  // Output decode from the next state so outputs track state_q exactly.
  always_comb begin
    loop_rst_d = (state_d == StIdle) || (state_d == StLoopRst);
    gain_sel_d = (state_d == StIdle) || (state_d == StLoopRst) || (state_d == StCoarse);
    locked_d   = (state_d == StLocked);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_sync_q  <= '0;
      dn_sync_q  <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      err_last_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      acq_q      <= '0;
      lost_q     <= 1'b0;
      fail_q     <= 1'b0;
      loop_rst_q <= 1'b1;
      gain_sel_q <= 1'b1;
      locked_q   <= 1'b0;
    end else begin
      up_sync_q  <= {up_sync_q[0], up_i};
      dn_sync_q  <= {dn_sync_q[0], dn_i};
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_last_q <= err_last_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      acq_q      <= acq_d;
      lost_q     <= lost_d;
      fail_q     <= fail_d;
      loop_rst_q <= loop_rst_d;
      gain_sel_q <= gain_sel_d;
      locked_q   <= locked_d;
    end
  end

  assign loop_rst_o  = loop_rst_q;
  assign gain_sel_o  = gain_sel_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lost_q;
  assign acq_fail_o  = fail_q;
  assign state_o     = state_q;
  assign err_last_o  = err_last_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl: directed scenarios plus randomized PFD activity, all checked
// against a window-level behavioural model of the lock supervisor.
module tb_pll_lock_ctrl;

  localparam int WinLen  = 16;
  localparam int CThr    = 6;
  localparam int FThr    = 1;
  localparam int LockW   = 3;
  localparam int UnlockW = 2;
  localparam int RstCyc  = 4;
  localparam int TmoW    = 8;

  localparam int MIdle   = 0;
  localparam int MLoopRst = 1;
  localparam int MCoarse = 2;
  localparam int MFine   = 3;
  localparam int MLocked = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic       clr = 1'b0;
  logic       loop_rst_o, gain_sel_o, locked_o, lock_lost_o, acq_fail_o;
  logic [2:0] state_o;
  logic [4:0] err_last_o;
  logic [12:0] dut_vec;

  int checks = 0;
  int errors = 0;

  pll_lock_ctrl #(
    .WIN_LEN     (WinLen),
    .COARSE_THR  (CThr),
    .FINE_THR    (FThr),
    .LOCK_WINS   (LockW),
    .UNLOCK_WINS (UnlockW),
    .RST_CYCLES  (RstCyc),
    .TIMEOUT_WINS(TmoW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .up_i       (up),
    .dn_i       (dn),
    .clr_lost_i (clr),
    .loop_rst_o (loop_rst_o),
    .gain_sel_o (gain_sel_o),
    .locked_o   (locked_o),
    .lock_lost_o(lock_lost_o),
    .acq_fail_o (acq_fail_o),
    .state_o    (state_o),
    .err_last_o (err_last_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state_o, loop_rst_o, gain_sel_o, locked_o, lock_lost_o, acq_fail_o,
                    err_last_o};

  // ---------------- behavioural model ----------------
  logic [1:0] sync_q[$];  // PFD samples in flight through the two-stage synchronizer
  int  m_state, m_cyc, m_err, m_last, m_good, m_bad, m_acq;
  bit  m_lost, m_fail;

  task automatic model_reset();
    sync_q = {};
    sync_q.push_back(2'b00);
    sync_q.push_back(2'b00);
    m_state = MIdle;
    m_cyc = 0; m_err = 0; m_last = 0; m_good = 0; m_bad = 0; m_acq = 0;
    m_lost = 0; m_fail = 0;
  endtask

  task automatic model_step();
    logic [1:0] s;
    int  e, nxt, tot;
    bit  win_end, s_lost, s_fail;
    s = sync_q.pop_front();
    sync_q.push_back({up, dn});
    e = int'(s[1] ^ s[0]);
    nxt = m_state; s_lost = 0; s_fail = 0;
    win_end = (m_state >= MCoarse) && (((m_cyc + 1) % WinLen) == 0);
    tot = m_err + e;
    if (tot > WinLen) tot = WinLen;
    if (win_end) begin
      m_last = tot;
      if (m_state != MLocked) begin
        m_acq++;
        if (m_acq == TmoW) begin nxt = MLoopRst; s_fail = 1; end
        else if (m_state == MCoarse) begin if (tot <= CThr) nxt = MFine; end
        else if (tot <= FThr) begin m_good++; if (m_good == LockW) nxt = MLocked; end
        else if (tot <= CThr) m_good = 0;
        else nxt = MCoarse;
      end else begin
        if (tot > FThr) m_bad++; else m_bad = 0;
        if (m_bad == UnlockW) begin nxt = MFine; s_lost = 1; end
      end
    end
    if (m_state == MIdle) nxt = MLoopRst;
    if (m_state == MLoopRst && m_cyc == RstCyc - 1) nxt = MCoarse;
    if (!en) begin nxt = MIdle; s_lost = 0; s_fail = 0; end
    m_lost = s_lost ? 1'b1 : (clr ? 1'b0 : m_lost);
    m_fail = s_fail ? 1'b1 : (clr ? 1'b0 : m_fail);
    if (nxt != m_state) begin
      m_cyc = 0; m_err = 0; m_good = 0; m_bad = 0;
      if (nxt == MIdle || nxt == MLoopRst || nxt == MLocked) m_acq = 0;
    end else begin
      m_cyc++;
      m_err = (m_state < MCoarse || win_end) ? 0 : tot;
    end
    m_state = nxt;
  endtask

  function automatic logic [12:0] exp_vec();
    return {3'(m_state), m_state <= MLoopRst, m_state <= MCoarse, m_state == MLocked,
            m_lost, m_fail, 5'(m_last)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    en = 0; up = 0; dn = 0; clr = 0;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] rv;
    rv = 13'b000_1_1_0_0_0_00000;
    en = 1; up = 1; dn = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== rv) begin
      errors++; $display("FAIL reset_values: got %h want %h", dut_vec, rv);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 0; up = 0;
  endtask

  task automatic test_acquire();
    int es;
    en = 1; up = 0; dn = 0;
    for (int i = 0; i < 72; i++) begin
      tick();
      es = (i < 4) ? 1 : (i < 20) ? 2 : (i < 68) ? 3 : 4;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL acquire_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (state_o !== 3'(es)) begin
        errors++; $display("FAIL acquire_schedule cyc %0d: state %0d want %0d", i, state_o, es);
      end
    end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 36; i++) begin
      dn = ((i % 16) < 4);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL unlock_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    dn = 0;
    checks++;
    if (state_o !== 3'd3 || lock_lost_o !== 1'b1 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL unlock_state: state %0d lost %b locked %b want 3 1 0",
               state_o, lock_lost_o, locked_o);
    end
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (lock_lost_o !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL unlock_clear: lost %b want 0 (vec %h want %h)",
                         lock_lost_o, dut_vec, exp_vec());
    end
  endtask

  task automatic test_both_high();
    do_reset();
    en = 1; up = 1; dn = 1;
    for (int i = 0; i < 72; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL both_high_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked_o !== 1'b1 || err_last_o !== 5'd0) begin
      errors++; $display("FAIL both_high_lock: locked %b err_last %0d want 1 0", locked_o, err_last_o);
    end
    up = 0; dn = 0;
  endtask

  task automatic test_fine_coarse();
    do_reset();
    en = 1;
    for (int i = 0; i < 40; i++) begin
      up = (i >= 24 && i < 32);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fine_coarse_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (state_o !== 3'd2 || gain_sel_o !== 1'b1 || err_last_o !== 5'd8) begin
      errors++;
      $display("FAIL fine_to_coarse: state %0d gain %b err_last %0d want 2 1 8",
               state_o, gain_sel_o, err_last_o);
    end
    up = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1;
    for (int i = 0; i < 136; i++) begin
      up = ((i % 16) < 10);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timeout_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (acq_fail_o !== (i >= 132)) begin
        errors++; $display("FAIL timeout_flag cyc %0d: acq_fail %b want %b", i, acq_fail_o, i >= 132);
      end
    end
    checks++;
    if (state_o !== 3'd1 || loop_rst_o !== 1'b1) begin
      errors++; $display("FAIL timeout_retry: state %0d loop_rst %b want 1 1", state_o, loop_rst_o);
    end
    up = 0; clr = 1;
    tick();
    clr = 0;
    checks++;
    if (acq_fail_o !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: acq_fail %b want 0", acq_fail_o);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1;
    for (int i = 0; i < 72; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL en_drop_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    en = 0;
    tick();
    checks++;
    if (state_o !== 3'd0 || loop_rst_o !== 1'b1 || locked_o !== 1'b0 || gain_sel_o !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_idle: state %0d loop_rst %b locked %b gain %b want 0 1 0 1",
               state_o, loop_rst_o, locked_o, gain_sel_o);
    end
  endtask

  task automatic test_rst_mid();
    logic [12:0] rv;
    rv = 13'b000_1_1_0_0_0_00000;
    do_reset();
    en = 1; up = 1;
    for (int i = 0; i < 24; i++) begin
      up = (i % 5 == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== rv) begin
      errors++; $display("FAIL rst_mid_values: got %h want %h", dut_vec, rv);
    end
    en = 0; up = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int lv[7] = '{0, 0, 0, 3, 8, 30, 60};
    int pu, pd;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      pu = 0; pd = 0;
      for (int c = 0; c < 500; c++) begin
        if (c % 16 == 0) begin
          pu = lv[$urandom_range(0, 6)];
          pd = lv[$urandom_range(0, 6)];
        end
        up  = ($urandom_range(0, 99) < pu);
        dn  = ($urandom_range(0, 99) < pd);
        en  = ($urandom_range(0, 299) != 0);
        clr = ($urandom_range(0, 39) == 0);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL random r%0d cyc %0d: got %h want %h", r, c, dut_vec, exp_vec());
        end
      end
    end
    en = 0; up = 0; dn = 0; clr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_acquire();
    test_unlock();
    test_both_high();
    test_fine_coarse();
    test_timeout();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
